ubus_sequencer: RTL and testbench
=================================

Name: ubus_sequencer

Overview:
Parametrised successor to the single-cycle write-bus/branch-compare logic. It accepts micro-ops over a valid/ready handshake, selects one of SRC_COUNT producers onto a registered shared bus, and strobes a one-hot write enable to one of DST_COUNT consumers. It also owns the micro-PC: sequential increment, conditional branch, jump, and call/return through a hardware return stack. It sits between the micro-decode ROM and the datapath producer/consumer registers.

Parameters:
DATA_WIDTH, 8, bus and producer data width
SRC_COUNT, 16, number of producer inputs on the bus
DST_COUNT, 16, number of consumer write-enable lines
MPC_WIDTH, 8, micro-PC width
STACK_DEPTH, 4, return-stack entries (power of 2, >=2)

Ports:
sys_clk  in  1  clock
sys_rst  in  1  synchronous active-high reset
uop_valid  in  1  micro-op present
uop_ready  out  1  micro-op accepted this cycle when valid&ready
uop_type  in  3  000 NOP, 001 MOVE, 010 MOVE_IMM, 011 BRANCH_EQ, 100 JUMP, 101 CALL, 110 RET, 111 reserved
uop_src  in  $clog2(SRC_COUNT)  producer index
uop_dst  in  $clog2(DST_COUNT)  consumer index
uop_imm  in  DATA_WIDTH  immediate / branch compare value
uop_target  in  MPC_WIDTH  branch/jump/call target
src_data  in  SRC_COUNT*DATA_WIDTH  flattened producers, index i at [i*DATA_WIDTH +: DATA_WIDTH]
dst_ready  in  DST_COUNT  per-consumer ready
bus_data  out  DATA_WIDTH  registered shared bus value
dst_we  out  DST_COUNT  one-hot consumer write strobe
m_pc  out  MPC_WIDTH  current micro-PC
stack_err  out  1  sticky return-stack over/underflow flag

Behaviour:
- Reset (sys_rst=1 at a posedge): m_pc=0, bus_data=0, dst_we=0, stack pointer=0, stack_err=0, transfer stage empty. uop_ready=0 while sys_rst is high. Reset overrides any in-flight transfer, which is dropped.
- Single transfer stage (stg_valid, stg_dst, stg_data).
- uop_ready = !sys_rst && (!stg_valid || dst_ready[stg_dst]).
- Accept (uop_valid&uop_ready, cycle N): source is sampled in cycle N. For MOVE, stage loads src_data[uop_src]; a uop_src >= SRC_COUNT yields 0. For MOVE_IMM, stage loads uop_imm. Other types leave the stage empty unless it retires.
- Cycle N+1: bus_data = stg_data. dst_we[stg_dst] = stg_valid && dst_ready[stg_dst] && stg_dst < DST_COUNT.
  - An out-of-range dst retires without a strobe.
  - If dst_ready is low, the stage holds, bus_data stays stable, dst_we=0, and uop_ready=0 until ready.
- Retire and new accept in the same cycle: the stage reloads back-to-back, giving a throughput of 1 uop/cycle.
- bus_data retains its last value when the stage is empty; dst_we is all-zero.
- m_pc updates only on accept, and is evaluated in cycle N with values sampled then:
  - NOP/MOVE/MOVE_IMM/reserved: m_pc+1
  - BRANCH_EQ: uop_target if src_data[uop_src]==uop_imm, else m_pc+1
  - JUMP: uop_target
  - CALL: push m_pc+1, m_pc=uop_target. If the stack is full: no push, m_pc=m_pc+1, stack_err<=1.
  - RET: pop into m_pc. If the stack is empty: m_pc=m_pc+1, stack_err<=1.
- m_pc arithmetic is modulo 2^MPC_WIDTH (0xFF+1 -> 0x00).
- The stack pointer saturates and never wraps. stack_err clears only on reset.
- No m_pc change when no uop is accepted.

Test Plan:
1. Reset, then MOVE src=3 (src_data[3]=0xA5) dst=7 with all dst_ready=1 -> next cycle bus_data=0xA5, dst_we=0x0080, m_pc=1.
2. Back-to-back MOVE_IMM imm=0x11 dst=2, then imm=0x22 dst=4 -> dst_we=0x0004/bus 0x11, then 0x0010/bus 0x22 on consecutive cycles. uop_ready stays 1.
3. MOVE dst=5 with dst_ready[5]=0 for 3 cycles -> uop_ready=0 and bus_data held for 3 cycles. Single dst_we pulse when ready rises; the next uop is accepted that cycle.
4. BRANCH_EQ src=1 imm=0x01 target=0x40 with src_data[1]=0x01 -> m_pc=0x40. Repeat with src_data[1]=0x00 -> m_pc=0x41. JUMP from m_pc=0xFF-less path: NOP at m_pc=0xFF -> m_pc=0x00.
5. CALL target=0x10 at m_pc=0x05, then RET -> m_pc=0x10 then 0x06. Five nested CALLs with STACK_DEPTH=4 -> 5th sets stack_err=1, m_pc=prev+1. RET on empty stack -> stack_err stays 1.
6. Assert sys_rst while a stalled MOVE is in the stage -> dst_we never pulses, m_pc=0, stack_err=0, uop_ready=0 during reset and 1 the cycle after.

Source files
------------

// File: rtl/ubus_sequencer.sv
// rtl/ubus_sequencer.sv - micro-op bus sequencer with shared bus transfer stage and micro-PC return stack
//
// Accepts micro-ops over a valid/ready handshake. MOVE and MOVE_IMM load a single
// transfer stage that drives the registered shared bus and strobes one consumer
// write enable. The micro-PC advances or branches on every accepted micro-op.
// CALL and RET use a small saturating hardware return stack.
//
// Ports:
//   sys_clk, sys_rst      clock, synchronous active-high reset
//   uop_valid/uop_ready   micro-op handshake
//   uop_type              000 NOP, 001 MOVE, 010 MOVE_IMM, 011 BRANCH_EQ,
//                         100 JUMP, 101 CALL, 110 RET, 111 reserved
//   uop_src, uop_dst      producer / consumer index
//   uop_imm, uop_target   immediate or compare value, and micro-PC target
//   src_data              flattened producers, index i at [i*DATA_WIDTH +: DATA_WIDTH]
//   dst_ready             per-consumer ready
//   bus_data              registered shared bus value
//   dst_we                one-hot consumer write strobe
//   m_pc                  current micro-PC
//   stack_err             sticky return-stack overflow/underflow flag
module ubus_sequencer #(
   parameter int DATA_WIDTH  = 8,
   parameter int SRC_COUNT   = 16,
   parameter int DST_COUNT   = 16,
   parameter int MPC_WIDTH   = 8,
   parameter int STACK_DEPTH = 4
) (
   input  logic                                 sys_clk,
   input  logic                                 sys_rst,
   input  logic                                 uop_valid,
   output logic                                 uop_ready,
   input  logic [2:0]                           uop_type,
   input  logic [$clog2(SRC_COUNT)-1:0]         uop_src,
   input  logic [$clog2(DST_COUNT)-1:0]         uop_dst,
   input  logic [DATA_WIDTH-1:0]                uop_imm,
   input  logic [MPC_WIDTH-1:0]                 uop_target,
   input  logic [SRC_COUNT*DATA_WIDTH-1:0]      src_data,
   input  logic [DST_COUNT-1:0]                 dst_ready,
   output logic [DATA_WIDTH-1:0]                bus_data,
   output logic [DST_COUNT-1:0]                 dst_we,
   output logic [MPC_WIDTH-1:0]                 m_pc,
   output logic                                 stack_err
);

   localparam int SRC_W = $clog2(SRC_COUNT);
   localparam int DST_W = $clog2(DST_COUNT);
   localparam int SP_W  = $clog2(STACK_DEPTH) + 1;

   localparam logic [SRC_W:0]     SRC_LIM = (SRC_W+1)'(SRC_COUNT);
   localparam logic [DST_W:0]     DST_LIM = (DST_W+1)'(DST_COUNT);
   localparam logic [SP_W-1:0]    SP_FULL = SP_W'(STACK_DEPTH);
   localparam logic [SP_W-1:0]    SP_ONE  = SP_W'(1);
   localparam logic [MPC_WIDTH-1:0] PC_ONE = MPC_WIDTH'(1);

   typedef enum logic [2:0] {
      UOP_NOP      = 3'b000,
      UOP_MOVE     = 3'b001,
      UOP_MOVE_IMM = 3'b010,
      UOP_BRANCH   = 3'b011,
      UOP_JUMP     = 3'b100,
      UOP_CALL     = 3'b101,
      UOP_RET      = 3'b110,
      UOP_RSVD     = 3'b111
   } uop_t;

   // Transfer stage; stg_data doubles as the registered bus value.
   logic                    stg_valid;
   logic [DST_W-1:0]        stg_dst;
   logic [DATA_WIDTH-1:0]   stg_data;

   logic [MPC_WIDTH-1:0]    stack_mem [STACK_DEPTH];
   logic [SP_W-1:0]         sp;
   logic [SP_W-1:0]         sp_top;

   logic [DATA_WIDTH-1:0]   src_arr [SRC_COUNT];
   logic [DATA_WIDTH-1:0]   src_sel;
   logic                    src_ok;
   logic                    stg_dst_ok;
   logic                    stg_ready;
   logic                    retire;
   logic                    accept;
   logic [MPC_WIDTH-1:0]    pc_inc;
   uop_t                    op;

   for (genvar i = 0; i < SRC_COUNT; i++) begin : g_src
      assign src_arr[i] = src_data[i*DATA_WIDTH +: DATA_WIDTH];
   end

   assign op      = uop_t'(uop_type);
   assign src_ok  = {1'b0, uop_src} < SRC_LIM;
   assign src_sel = src_ok ? src_arr[uop_src] : '0;
   assign pc_inc  = m_pc + PC_ONE;
   assign sp_top  = sp - SP_ONE;

   // An out-of-range destination has no ready line; it retires immediately.
   assign stg_dst_ok = {1'b0, stg_dst} < DST_LIM;
   assign stg_ready  = stg_dst_ok ? dst_ready[stg_dst] : 1'b1;
   assign retire     = stg_valid && stg_ready;

   assign uop_ready = !sys_rst && (!stg_valid || stg_ready);
   assign accept    = uop_valid && uop_ready;
   assign bus_data  = stg_data;

   always_comb begin
      dst_we = '0;
      if (stg_valid && stg_ready && stg_dst_ok) begin
         dst_we[stg_dst] = 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         stg_valid <= 1'b0;
         stg_dst   <= '0;
         stg_data  <= '0;
         m_pc      <= '0;
         sp        <= '0;
         stack_err <= 1'b0;
      end else begin
         // Stage: a new MOVE/MOVE_IMM reloads it (back-to-back with a retire),
         // otherwise a retiring entry empties it.
         if (accept && (op == UOP_MOVE || op == UOP_MOVE_IMM)) begin
            stg_valid <= 1'b1;
            stg_dst   <= uop_dst;
            stg_data  <= (op == UOP_MOVE) ? src_sel : uop_imm;
         end else if (retire) begin
            stg_valid <= 1'b0;
         end

         if (accept) begin
            case (op)
               UOP_BRANCH: m_pc <= (src_sel == uop_imm) ? uop_target : pc_inc;
               UOP_JUMP:   m_pc <= uop_target;
               UOP_CALL: begin
                  if (sp == SP_FULL) begin
                     m_pc      <= pc_inc;
                     stack_err <= 1'b1;
                  end else begin
                     stack_mem[sp[SP_W-2:0]] <= pc_inc;
                     sp                      <= sp + SP_ONE;
                     m_pc                    <= uop_target;
                  end
               end
               UOP_RET: begin
                  if (sp == '0) begin
                     m_pc      <= pc_inc;
                     stack_err <= 1'b1;
                  end else begin
                     m_pc <= stack_mem[sp_top[SP_W-2:0]];
                     sp   <= sp_top;
                  end
               end
               default:    m_pc <= pc_inc;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ubus_sequencer.sv
// tb/tb_ubus_sequencer.sv - directed self-checking bench for ubus_sequencer
module tb_ubus_sequencer;

   logic          sys_clk;
   logic          sys_rst;
   logic          uop_valid;
   logic          uop_ready;
   logic [2:0]    uop_type;
   logic [3:0]    uop_src;
   logic [3:0]    uop_dst;
   logic [7:0]    uop_imm;
   logic [7:0]    uop_target;
   logic [127:0]  src_data;
   logic [15:0]   dst_ready;
   logic [7:0]    bus_data;
   logic [15:0]   dst_we;
   logic [7:0]    m_pc;
   logic          stack_err;

   int tests_run;
   int tests_failed;

   localparam logic [2:0] T_NOP = 3'b000, T_MOVE = 3'b001, T_IMM = 3'b010,
                          T_BEQ = 3'b011, T_JMP = 3'b100, T_CALL = 3'b101,
                          T_RET = 3'b110;

   ubus_sequencer dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .uop_valid (uop_valid),
      .uop_ready (uop_ready),
      .uop_type  (uop_type),
      .uop_src   (uop_src),
      .uop_dst   (uop_dst),
      .uop_imm   (uop_imm),
      .uop_target(uop_target),
      .src_data  (src_data),
      .dst_ready (dst_ready),
      .bus_data  (bus_data),
      .dst_we    (dst_we),
      .m_pc      (m_pc),
      .stack_err (stack_err)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] t, input logic [3:0] s, input logic [3:0] d,
                        input logic [7:0] imm, input logic [7:0] tgt);
      uop_valid  = 1'b1;
      uop_type   = t;
      uop_src    = s;
      uop_dst    = d;
      uop_imm    = imm;
      uop_target = tgt;
   endtask

   task automatic test_reset();
      sys_rst = 1'b1;
      uop_valid = 1'b0;
      uop_type = T_NOP; uop_src = '0; uop_dst = '0; uop_imm = '0; uop_target = '0;
      src_data = '0;
      dst_ready = '1;
      tick(); tick();
      tests_run++; if (m_pc !== 8'h00) begin tests_failed++; $display("FAIL reset_m_pc got %h expected 00", m_pc); end
      tests_run++; if (bus_data !== 8'h00) begin tests_failed++; $display("FAIL reset_bus got %h expected 00", bus_data); end
      tests_run++; if (dst_we !== 16'h0) begin tests_failed++; $display("FAIL reset_we got %h expected 0000", dst_we); end
      tests_run++; if (stack_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err got %b expected 0", stack_err); end
      tests_run++; if (uop_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready_in_reset got %b expected 0", uop_ready); end
      sys_rst = 1'b0;
      #1;
      tests_run++; if (uop_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready_after got %b expected 1", uop_ready); end
   endtask

   task automatic test_move();
      src_data[3*8 +: 8] = 8'hA5;
      drive(T_MOVE, 4'd3, 4'd7, 8'h00, 8'h00);
      tick();
      uop_valid = 1'b0;
      tests_run++; if (bus_data !== 8'hA5) begin tests_failed++; $display("FAIL move_bus got %h expected a5", bus_data); end
      tests_run++; if (dst_we !== 16'h0080) begin tests_failed++; $display("FAIL move_we got %h expected 0080", dst_we); end
      tests_run++; if (m_pc !== 8'h01) begin tests_failed++; $display("FAIL move_pc got %h expected 01", m_pc); end
      tick();
      tests_run++; if (dst_we !== 16'h0) begin tests_failed++; $display("FAIL move_we_clear got %h expected 0000", dst_we); end
      tests_run++; if (bus_data !== 8'hA5) begin tests_failed++; $display("FAIL move_bus_hold got %h expected a5", bus_data); end
   endtask

   task automatic test_back_to_back();
      drive(T_IMM, 4'd0, 4'd2, 8'h11, 8'h00);
      tick();
      tests_run++; if (bus_data !== 8'h11) begin tests_failed++; $display("FAIL b2b_bus0 got %h expected 11", bus_data); end
      tests_run++; if (dst_we !== 16'h0004) begin tests_failed++; $display("FAIL b2b_we0 got %h expected 0004", dst_we); end
      tests_run++; if (uop_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready got %b expected 1", uop_ready); end
      drive(T_IMM, 4'd0, 4'd4, 8'h22, 8'h00);
      tick();
      uop_valid = 1'b0;
      tests_run++; if (bus_data !== 8'h22) begin tests_failed++; $display("FAIL b2b_bus1 got %h expected 22", bus_data); end
      tests_run++; if (dst_we !== 16'h0010) begin tests_failed++; $display("FAIL b2b_we1 got %h expected 0010", dst_we); end
      tests_run++; if (m_pc !== 8'h03) begin tests_failed++; $display("FAIL b2b_pc got %h expected 03", m_pc); end
      tick();
   endtask

   task automatic test_stall();
      src_data[2*8 +: 8] = 8'h5C;
      dst_ready[5] = 1'b0;
      drive(T_MOVE, 4'd2, 4'd5, 8'h00, 8'h00);
      tick();
      drive(T_IMM, 4'd0, 4'd6, 8'h33, 8'h00);
      for (int c = 0; c < 3; c++) begin
         #1;
         tests_run++; if (uop_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_ready[%0d] got %b expected 0", c, uop_ready); end
         tests_run++; if (bus_data !== 8'h5C) begin tests_failed++; $display("FAIL stall_bus[%0d] got %h expected 5c", c, bus_data); end
         tests_run++; if (dst_we !== 16'h0) begin tests_failed++; $display("FAIL stall_we[%0d] got %h expected 0000", c, dst_we); end
         tests_run++; if (m_pc !== 8'h04) begin tests_failed++; $display("FAIL stall_pc[%0d] got %h expected 04", c, m_pc); end
         if (c < 2) tick();
      end
      dst_ready[5] = 1'b1;
      #1;
      tests_run++; if (dst_we !== 16'h0020) begin tests_failed++; $display("FAIL stall_release_we got %h expected 0020", dst_we); end
      tests_run++; if (uop_ready !== 1'b1) begin tests_failed++; $display("FAIL stall_release_ready got %b expected 1", uop_ready); end
      tick();
      uop_valid = 1'b0;
      tests_run++; if (bus_data !== 8'h33) begin tests_failed++; $display("FAIL stall_next_bus got %h expected 33", bus_data); end
      tests_run++; if (dst_we !== 16'h0040) begin tests_failed++; $display("FAIL stall_next_we got %h expected 0040", dst_we); end
      tests_run++; if (m_pc !== 8'h05) begin tests_failed++; $display("FAIL stall_next_pc got %h expected 05", m_pc); end
      tick();
   endtask

   task automatic test_branch();
      src_data[1*8 +: 8] = 8'h01;
      drive(T_BEQ, 4'd1, 4'd0, 8'h01, 8'h40);
      tick();
      tests_run++; if (m_pc !== 8'h40) begin tests_failed++; $display("FAIL beq_taken got %h expected 40", m_pc); end
      tests_run++; if (dst_we !== 16'h0) begin tests_failed++; $display("FAIL beq_we got %h expected 0000", dst_we); end
      src_data[1*8 +: 8] = 8'h00;
      tick();
      tests_run++; if (m_pc !== 8'h41) begin tests_failed++; $display("FAIL beq_not_taken got %h expected 41", m_pc); end
      drive(T_JMP, 4'd0, 4'd0, 8'h00, 8'hFF);
      tick();
      tests_run++; if (m_pc !== 8'hFF) begin tests_failed++; $display("FAIL jump got %h expected ff", m_pc); end
      drive(T_NOP, 4'd0, 4'd0, 8'h00, 8'h00);
      tick();
      uop_valid = 1'b0;
      tests_run++; if (m_pc !== 8'h00) begin tests_failed++; $display("FAIL pc_wrap got %h expected 00", m_pc); end
      tick();
      tests_run++; if (m_pc !== 8'h00) begin tests_failed++; $display("FAIL pc_idle got %h expected 00", m_pc); end
   endtask

   task automatic test_call_ret();
      logic [7:0] ret_exp [4];
      ret_exp[0] = 8'h41; ret_exp[1] = 8'h31; ret_exp[2] = 8'h21; ret_exp[3] = 8'h07;
      drive(T_JMP, 4'd0, 4'd0, 8'h00, 8'h05);
      tick();
      drive(T_CALL, 4'd0, 4'd0, 8'h00, 8'h10);
      tick();
      tests_run++; if (m_pc !== 8'h10) begin tests_failed++; $display("FAIL call got %h expected 10", m_pc); end
      drive(T_RET, 4'd0, 4'd0, 8'h00, 8'h00);
      tick();
      tests_run++; if (m_pc !== 8'h06) begin tests_failed++; $display("FAIL ret got %h expected 06", m_pc); end
      tests_run++; if (stack_err !== 1'b0) begin tests_failed++; $display("FAIL call_ret_err got %b expected 0", stack_err); end
      for (int k = 0; k < 4; k++) begin
         drive(T_CALL, 4'd0, 4'd0, 8'h00, 8'(8'h20 + k * 8'h10));
         tick();
      end
      tests_run++; if (m_pc !== 8'h50) begin tests_failed++; $display("FAIL nest4_pc got %h expected 50", m_pc); end
      tests_run++; if (stack_err !== 1'b0) begin tests_failed++; $display("FAIL nest4_err got %b expected 0", stack_err); end
      drive(T_CALL, 4'd0, 4'd0, 8'h00, 8'h60);
      tick();
      tests_run++; if (m_pc !== 8'h51) begin tests_failed++; $display("FAIL overflow_pc got %h expected 51", m_pc); end
      tests_run++; if (stack_err !== 1'b1) begin tests_failed++; $display("FAIL overflow_err got %b expected 1", stack_err); end
      for (int k = 0; k < 4; k++) begin
         drive(T_RET, 4'd0, 4'd0, 8'h00, 8'h00);
         tick();
         tests_run++; if (m_pc !== ret_exp[k]) begin tests_failed++; $display("FAIL pop[%0d] got %h expected %h", k, m_pc, ret_exp[k]); end
      end
      drive(T_RET, 4'd0, 4'd0, 8'h00, 8'h00);
      tick();
      uop_valid = 1'b0;
      tests_run++; if (m_pc !== 8'h08) begin tests_failed++; $display("FAIL underflow_pc got %h expected 08", m_pc); end
      tests_run++; if (stack_err !== 1'b1) begin tests_failed++; $display("FAIL underflow_err got %b expected 1", stack_err); end
   endtask

   task automatic test_reset_in_flight();
      dst_ready[9] = 1'b0;
      drive(T_IMM, 4'd0, 4'd9, 8'h77, 8'h00);
      tick();
      uop_valid = 1'b0;
      tests_run++; if (bus_data !== 8'h77) begin tests_failed++; $display("FAIL rif_stalled_bus got %h expected 77", bus_data); end
      sys_rst = 1'b1;
      #1;
      tests_run++; if (uop_ready !== 1'b0) begin tests_failed++; $display("FAIL rif_ready_rst got %b expected 0", uop_ready); end
      tick();
      tests_run++; if (m_pc !== 8'h00) begin tests_failed++; $display("FAIL rif_pc got %h expected 00", m_pc); end
      tests_run++; if (stack_err !== 1'b0) begin tests_failed++; $display("FAIL rif_err got %b expected 0", stack_err); end
      tests_run++; if (uop_ready !== 1'b0) begin tests_failed++; $display("FAIL rif_ready_hold got %b expected 0", uop_ready); end
      dst_ready = '1;
      #1;
      tests_run++; if (dst_we !== 16'h0) begin tests_failed++; $display("FAIL rif_we_dropped got %h expected 0000", dst_we); end
      sys_rst = 1'b0;
      tick();
      tests_run++; if (uop_ready !== 1'b1) begin tests_failed++; $display("FAIL rif_ready_after got %b expected 1", uop_ready); end
      tests_run++; if (dst_we !== 16'h0) begin tests_failed++; $display("FAIL rif_we_after got %h expected 0000", dst_we); end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
      test_move();
      test_back_to_back();
      test_stall();
      test_branch();
      test_call_ret();
      test_reset_in_flight();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
